// File: rtl/sort_result_streamer.sv
// Watches three processor memory words, snapshots them once stable, checks ascending
// signed order and streams a 26-byte frame (header, 3x64b LE, sorted flag) over valid/ready.
module sort_result_streamer #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter logic [7:0]  HEADER_BYTE   = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] elem1,
  input  logic [63:0] elem2,
  input  logic [63:0] elem3,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        busy,
  output logic        done,
  output logic        sorted_ok
);

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);
  localparam logic [4:0] LAST_IDX   = 5'd25;

  typedef enum logic [1:0] {WATCH, SEND, DONE} state_t;

  state_t           state, state_nxt;
  logic [2:0][63:0] cur, prev, snap, prev_d, snap_d;
  logic [7:0]       stable_cnt, cnt_inc, cnt_d;
  logic [4:0]       byte_idx, idx_d;
  logic [7:0]       data_d, next_byte;
  logic             valid_d, busy_d, done_d, ok_d;
  logic             match_prev, match_snap, capture, xfer, order_ok;
  logic [191:0]     payload;

  // cur[2] is elem1; payload puts elem1 in the low bytes so frame byte k+1 is payload byte k
  assign cur        = {elem1, elem2, elem3};
  assign payload    = {snap[0], snap[1], snap[2]};
  assign match_prev = (cur == prev);
  assign match_snap = (cur == snap);
  assign cnt_inc    = (stable_cnt >= STABLE_MAX) ? STABLE_MAX : stable_cnt + 8'd1;
  assign capture    = (state == WATCH) && match_prev && (cnt_inc == STABLE_MAX);
  assign xfer       = out_valid && out_ready;
  assign order_ok   = ($signed(elem1) <= $signed(elem2)) && ($signed(elem2) <= $signed(elem3));
  assign next_byte  = (byte_idx == LAST_IDX - 5'd1) ? {7'b0, sorted_ok}
                                                   : payload[{byte_idx, 3'b000} +: 8];

  always_ff @(posedge clk) begin
    if (reset) state <= WATCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      WATCH:   if (capture) state_nxt = SEND;
      SEND:    if (xfer && byte_idx == LAST_IDX) state_nxt = DONE;
      DONE:    if (!match_snap) state_nxt = WATCH;
      default: state_nxt = WATCH;
    endcase
  end

  always_comb begin
    prev_d  = prev;
    snap_d  = snap;
    cnt_d   = stable_cnt;
    idx_d   = byte_idx;
    data_d  = out_data;
    valid_d = out_valid;
    busy_d  = busy;
    done_d  = done;
    ok_d    = sorted_ok;
    unique case (state)
      WATCH: begin
        prev_d = cur;
        cnt_d  = match_prev ? cnt_inc : 8'd0;
        if (capture) begin
          snap_d  = cur;
          ok_d    = order_ok;
          idx_d   = 5'd0;
          valid_d = 1'b1;
          data_d  = HEADER_BYTE;
          busy_d  = 1'b1;
        end
      end
      SEND: begin
        // data/valid simply hold while stalled; no bubble between bytes
        if (xfer) begin
          if (byte_idx == LAST_IDX) begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d  = byte_idx + 5'd1;
            data_d = next_byte;
          end
        end
      end
      DONE: begin
        if (!match_snap) begin
          done_d = 1'b0;
          cnt_d  = 8'd0;
          prev_d = cur;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev       <= '0;
      snap       <= '0;
      stable_cnt <= '0;
      byte_idx   <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sorted_ok  <= 1'b0;
    end else begin
      prev       <= prev_d;
      snap       <= snap_d;
      stable_cnt <= cnt_d;
      byte_idx   <= idx_d;
      out_data   <= data_d;
      out_valid  <= valid_d;
      busy       <= busy_d;
      done       <= done_d;
      sorted_ok  <= ok_d;
    end
  end

endmodule

// File: tb/tb_sort_result_streamer.sv
// Directed bench for sort_result_streamer: capture timing, frame contents, stalls,
// input changes during a frame and mid-frame reset.
module tb_sort_result_streamer;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] elem1, elem2, elem3;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_valid, busy, done, sorted_ok;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  got [0:31];
  logic [7:0]  exp_f [0:25];

  sort_result_streamer #(.STABLE_CYCLES(16), .HEADER_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset), .elem1(elem1), .elem2(elem2), .elem3(elem3),
    .out_ready(out_ready), .out_data(out_data), .out_valid(out_valid),
    .busy(busy), .done(done), .sorted_ok(sorted_ok)
  );

  always #5 clk = ~clk;

  // one active edge, then settle on the falling edge for sampling/driving
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fill_exp(input logic [63:0] e1, input logic [63:0] e2,
                          input logic [63:0] e3, input logic ok);
    exp_f[0] = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      exp_f[1 + i]  = e1[8*i +: 8];
      exp_f[9 + i]  = e2[8*i +: 8];
      exp_f[17 + i] = e3[8*i +: 8];
    end
    exp_f[25] = {7'b0, ok};
  endtask

  // collects bytes with out_ready held high; stops early at stop_at, optionally
  // rewrites elem1 once chg_at bytes have been seen
  task automatic recv(input int max_cyc, input int stop_at, input int chg_at,
                      input logic [63:0] chg_v, output int n);
    bit started;
    started = 1'b0;
    n = 0;
    for (int c = 0; c < max_cyc; c++) begin
      if (n == stop_at) return;
      if (out_valid) begin
        if (n < 32) got[n] = out_data;
        n++;
        started = 1'b1;
        if (n == chg_at) elem1 = chg_v;
      end else if (started) begin
        return;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; out_ready = 1'b1;
    elem1 = 64'd1; elem2 = 64'd2; elem3 = 64'd3;
    @(negedge clk);
    tick(); tick(); tick();
    n_cmp++;
    if ({out_valid, busy, done, sorted_ok, out_data} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_state: got v=%b b=%b d=%b ok=%b data=%h want all 0",
               out_valid, busy, done, sorted_ok, out_data);
    end
  endtask

  task automatic test_basic();
    int n;
    reset = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL basic_early: out_valid=%b after edge 16, want 0", out_valid);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL basic_capture: v=%b data=%h busy=%b after edge 17, want 1 a5 1",
               out_valid, out_data, busy);
    end
    recv(40, -1, -1, 64'd0, n);
    fill_exp(64'd1, 64'd2, 64'd3, 1'b1);
    n_cmp++;
    if (n !== 26) begin n_err++; $display("FAIL basic_count: %0d bytes, want 26", n); end
    for (int i = 0; i < 26; i++) begin
      n_cmp++;
      if (got[i] !== exp_f[i]) begin
        n_err++; $display("FAIL basic_byte%0d: got %h want %h", i, got[i], exp_f[i]);
      end
    end
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || sorted_ok !== 1'b1) begin
      n_err++; $display("FAIL basic_end: done=%b busy=%b ok=%b want 1 0 1", done, busy, sorted_ok);
    end
  endtask

  task automatic test_unsorted();
    int n;
    elem1 = 64'd5; elem2 = 64'hFFFF_FFFF_FFFF_FFFF; elem3 = 64'd7;
    for (int i = 0; i < 16; i++) tick();
    n_cmp++;
    if (out_valid !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL unsorted_early: v=%b done=%b want 0 0", out_valid, done);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || sorted_ok !== 1'b0) begin
      n_err++; $display("FAIL unsorted_capture: v=%b ok=%b want 1 0", out_valid, sorted_ok);
    end
    recv(40, -1, -1, 64'd0, n);
    fill_exp(64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd7, 1'b0);
    n_cmp++;
    if (n !== 26) begin n_err++; $display("FAIL unsorted_count: %0d bytes, want 26", n); end
    for (int i = 0; i < 26; i++) begin
      n_cmp++;
      if (got[i] !== exp_f[i]) begin
        n_err++; $display("FAIL unsorted_byte%0d: got %h want %h", i, got[i], exp_f[i]);
      end
    end
  endtask

  task automatic test_toggle();
    int bad, wait_n, n;
    bad = 0;
    for (int t = 0; t < 6; t++) begin
      elem3 = (t % 2 == 0) ? 64'd8 : 64'd7;
      for (int c = 0; c < 10; c++) begin
        if (out_valid !== 1'b0) bad++;
        tick();
      end
    end
    n_cmp++;
    if (bad !== 0) begin n_err++; $display("FAIL toggle_quiet: out_valid high %0d cycles, want 0", bad); end
    elem3 = 64'd9;
    wait_n = 0;
    while (out_valid !== 1'b1 && wait_n < 40) begin tick(); wait_n++; end
    n_cmp++;
    if (wait_n !== 17) begin n_err++; $display("FAIL toggle_latency: capture after %0d edges, want 17", wait_n); end
    recv(40, -1, -1, 64'd0, n);
    n_cmp++;
    if (n !== 26) begin n_err++; $display("FAIL toggle_count: %0d bytes, want 26", n); end
  endtask

  task automatic test_stall();
    int xf, stall_left, c;
    bit started;
    elem1 = 64'd1; elem2 = 64'd2; elem3 = 64'd3;
    xf = 0; stall_left = 5; started = 1'b0;
    for (c = 0; c < 100; c++) begin
      if (out_valid) begin
        started = 1'b1;
        if (xf == 9 && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
          n_cmp++;
          if (out_data !== 8'h02 || out_valid !== 1'b1) begin
            n_err++; $display("FAIL stall_hold: data=%h v=%b want 02 1", out_data, out_valid);
          end
        end else begin
          out_ready = 1'b1;
          if (xf < 32) got[xf] = out_data;
          xf++;
        end
      end else if (started) begin
        break;
      end
      tick();
    end
    out_ready = 1'b1;
    fill_exp(64'd1, 64'd2, 64'd3, 1'b1);
    n_cmp++;
    if (xf !== 26) begin n_err++; $display("FAIL stall_count: %0d transfers, want 26", xf); end
    for (int i = 0; i < 26; i++) begin
      n_cmp++;
      if (got[i] !== exp_f[i]) begin
        n_err++; $display("FAIL stall_byte%0d: got %h want %h", i, got[i], exp_f[i]);
      end
    end
  endtask

  task automatic test_change_during_send();
    int n;
    elem1 = 64'd4; elem2 = 64'd5; elem3 = 64'd6;
    recv(80, -1, 5, 64'd100, n);
    fill_exp(64'd4, 64'd5, 64'd6, 1'b1);
    n_cmp++;
    if (n !== 26) begin n_err++; $display("FAIL chg_count: %0d bytes, want 26", n); end
    for (int i = 0; i < 26; i++) begin
      n_cmp++;
      if (got[i] !== exp_f[i]) begin
        n_err++; $display("FAIL chg_byte%0d: got %h want %h", i, got[i], exp_f[i]);
      end
    end
    tick();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL chg_rewatch: done=%b busy=%b v=%b want 0 0 0", done, busy, out_valid);
    end
    recv(80, -1, -1, 64'd0, n);
    fill_exp(64'd100, 64'd5, 64'd6, 1'b0);
    n_cmp++;
    if (n !== 26) begin n_err++; $display("FAIL chg_new_count: %0d bytes, want 26", n); end
    for (int i = 0; i < 26; i++) begin
      n_cmp++;
      if (got[i] !== exp_f[i]) begin
        n_err++; $display("FAIL chg_new_byte%0d: got %h want %h", i, got[i], exp_f[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    elem1 = 64'd7; elem2 = 64'd8; elem3 = 64'd9;
    recv(80, 12, -1, 64'd0, n);
    n_cmp++;
    if (n !== 12 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL rst_mid_reach: %0d bytes v=%b, want 12 1", n, out_valid);
    end
    reset = 1'b1;
    tick();
    n_cmp++;
    if ({out_valid, busy, done, sorted_ok} !== 4'b0000) begin
      n_err++; $display("FAIL rst_mid_clear: v=%b b=%b d=%b ok=%b want 0000",
                        out_valid, busy, done, sorted_ok);
    end
    reset = 1'b0;
    recv(80, -1, -1, 64'd0, n);
    fill_exp(64'd7, 64'd8, 64'd9, 1'b1);
    n_cmp++;
    if (n !== 26) begin n_err++; $display("FAIL rst_mid_count: %0d bytes, want 26", n); end
    for (int i = 0; i < 26; i++) begin
      n_cmp++;
      if (got[i] !== exp_f[i]) begin
        n_err++; $display("FAIL rst_mid_byte%0d: got %h want %h", i, got[i], exp_f[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_unsorted();
    test_toggle();
    test_stall();
    test_change_during_send();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
